// File: rtl/vault_pkg.sv
// vault_pkg
//   Shared definitions for the vault door sequencer: state codes, the
//   output decode table and small elaboration helpers.
package vault_pkg;

    typedef enum logic [2:0] {
        LOCKED    = 3'd0,
        VERIFY    = 3'd1,
        RELEASED  = 3'd2,
        DOOR_OPEN = 3'd3,
        ALARM     = 3'd4
    } vault_state_t;

    typedef struct packed {
        logic bolt_open;
        logic buzzer;
    } vault_outputs_t;

    // Output decode table: bolt retracted while the door may be moved,
    // buzzer only in the alarm state.
    function automatic vault_outputs_t decode_outputs(input vault_state_t s);
        vault_outputs_t o;
        o = '0;
        case (s)
            RELEASED,
            DOOR_OPEN: o.bolt_open = 1'b1;
            ALARM:     o.buzzer    = 1'b1;
            default:   o           = '0;
        endcase
        return o;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/vault_tick_gen.sv
// vault_tick_gen
//   Free-running prescaler producing a one-cycle tick every TICK_DIV clocks.
//   Ports:
//     clk   - system clock
//     rst_n - asynchronous active-low reset
//     tick  - registered one-cycle pulse, period TICK_DIV clocks
module vault_tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    if (TICK_DIV < 1) begin : g_param_error
        $error("vault_tick_gen: TICK_DIV must be >= 1");
    end

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (count == CW'(TICK_DIV - 1)) begin
            count <= '0;
            tick  <= 1'b1;
        end else begin
            count <= count + 1'b1;
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/vault_door_sequencer.sv
// vault_door_sequencer
//   Sequences the vault bolt solenoid and alarm from the lock controller's
//   authorization and the door sensor.
//   Ports:
//     clk         - system clock (only clock)
//     rst_n       - asynchronous active-low reset, release synchronized here
//     unlock      - authorization from upstream lock controller (async)
//     door_closed - door sensor, 1 = closed (async)
//     bolt_open   - 1 = bolt solenoid retracted (registered)
//     buzzer      - 1 = alarm sounding (registered)
//     state       - current FSM state code (registered)
module vault_door_sequencer
    import vault_pkg::*;
#(
    parameter int TICK_DIV    = 25_000_000,
    parameter int MIN_UNLOCK  = 2,
    parameter int OPEN_WINDOW = 20,
    parameter int AJAR_LIMIT  = 120
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       unlock,
    input  logic       door_closed,
    output logic       bolt_open,
    output logic       buzzer,
    output logic [2:0] state
);

    if (MIN_UNLOCK < 1 || OPEN_WINDOW < 1 || AJAR_LIMIT < 1) begin : g_param_error
        $error("vault_door_sequencer: MIN_UNLOCK, OPEN_WINDOW and AJAR_LIMIT must be >= 1");
    end

    localparam int MAX_LIMIT = max3(MIN_UNLOCK, OPEN_WINDOW, AJAR_LIMIT);
    localparam int TW        = $clog2(MAX_LIMIT + 1);

    // Reset asserts asynchronously, releases two clk edges after rst_n rises.
    logic [1:0] rst_sync;
    logic       core_rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign core_rst_n = rst_sync[1];

    // Input synchronizers; reset values match a locked, closed vault.
    logic unlock_meta, unlock_s;
    logic closed_meta, closed_s;

    always_ff @(posedge clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            unlock_meta <= 1'b0;
            unlock_s    <= 1'b0;
            closed_meta <= 1'b1;
            closed_s    <= 1'b1;
        end else begin
            unlock_meta <= unlock;
            unlock_s    <= unlock_meta;
            closed_meta <= door_closed;
            closed_s    <= closed_meta;
        end
    end

    logic tick;

    vault_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(core_rst_n),
        .tick (tick)
    );

    vault_state_t   state_q, state_d;
    vault_outputs_t outs_d;
    logic [TW-1:0]  timer;
    logic           to_min, to_window, to_ajar;

    // Timeout L fires on the L-th tick after state entry.
    assign to_min    = tick && (timer == TW'(MIN_UNLOCK - 1));
    assign to_window = tick && (timer == TW'(OPEN_WINDOW - 1));
    assign to_ajar   = tick && (timer == TW'(AJAR_LIMIT - 1));

    // Branch order within each state gives door > unlock > timeout priority.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOCKED: begin
                if (!closed_s)     state_d = ALARM;
                else if (unlock_s) state_d = VERIFY;
            end
            VERIFY: begin
                if (!closed_s)      state_d = ALARM;
                else if (!unlock_s) state_d = LOCKED;
                else if (to_min)    state_d = RELEASED;
            end
            RELEASED: begin
                if (!closed_s)      state_d = DOOR_OPEN;
                else if (!unlock_s) state_d = LOCKED;
                else if (to_window) state_d = LOCKED;
            end
            DOOR_OPEN: begin
                if (closed_s)     state_d = LOCKED;
                else if (to_ajar) state_d = ALARM;
            end
            ALARM: begin
                if (closed_s && !unlock_s) state_d = LOCKED;
            end
            default: state_d = ALARM;
        endcase
    end

    assign outs_d = decode_outputs(state_d);

    always_ff @(posedge clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state_q   <= LOCKED;
            bolt_open <= 1'b0;
            buzzer    <= 1'b0;
            timer     <= '0;
        end else begin
            state_q   <= state_d;
            bolt_open <= outs_d.bolt_open;
            buzzer    <= outs_d.buzzer;
            if (state_d != state_q)
                timer <= '0;
            else if (tick && (timer != '1))
                timer <= timer + 1'b1;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_vault_door_sequencer.sv
// tb_vault_door_sequencer
//   Directed scenarios plus randomized input traffic, each cycle compared
//   against a tick-counting behavioural model of the door rules.
module tb_vault_door_sequencer;

    localparam int TD = 4;
    localparam int MU = 2;
    localparam int OW = 3;
    localparam int AL = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       unlock = 1'b0;
    logic       door_closed = 1'b1;
    logic       bolt_open;
    logic       buzzer;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vault_door_sequencer #(
        .TICK_DIV   (TD),
        .MIN_UNLOCK (MU),
        .OPEN_WINDOW(OW),
        .AJAR_LIMIT (AL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .unlock     (unlock),
        .door_closed(door_closed),
        .bolt_open  (bolt_open),
        .buzzer     (buzzer),
        .state      (state)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: state number, ticks counted since entry, two-stage
    // view of each input, and the clock count since reset release.
    int m_state, m_ticks, m_edge, m_skip;
    bit u1, u2, c1, c2;

    task automatic model_reset();
        m_state = 0; m_ticks = 0; m_edge = 0; m_skip = 2;
        u1 = 1'b0; u2 = 1'b0; c1 = 1'b1; c2 = 1'b1;
    endtask

    task automatic model_edge();
        bit tk, us, cs;
        int nxt;
        if (m_skip > 0) begin
            m_skip--;
            return;
        end
        m_edge++;
        tk = (m_edge > 1) && ((m_edge - 1) % TD == 0);
        us = u2; cs = c2;
        u2 = u1; u1 = unlock;
        c2 = c1; c1 = door_closed;
        nxt = m_state;
        case (m_state)
            0: if (!cs) nxt = 4; else if (us) nxt = 1;
            1: if (!cs) nxt = 4; else if (!us) nxt = 0; else if (tk && m_ticks + 1 == MU) nxt = 2;
            2: if (!cs) nxt = 3; else if (!us) nxt = 0; else if (tk && m_ticks + 1 == OW) nxt = 0;
            3: if (cs) nxt = 0; else if (tk && m_ticks + 1 == AL) nxt = 4;
            4: if (cs && !us) nxt = 0;
            default: nxt = 4;
        endcase
        if (nxt != m_state) m_ticks = 0;
        else if (tk)        m_ticks++;
        m_state = nxt;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("state", int'(state), m_state);
        check("bolt", int'(bolt_open), (m_state == 2 || m_state == 3) ? 1 : 0);
        check("buzzer", int'(buzzer), (m_state == 4) ? 1 : 0);
    endtask

    // Called 1 time unit after a posedge; asserts reset mid-cycle.
    task automatic apply_reset(input int hold);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_state", int'(state), 0);
        check("rst_bolt", int'(bolt_open), 0);
        check("rst_buzzer", int'(buzzer), 0);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step();
        step();
    endtask

    task automatic run_until(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (m_state != target && n < budget) begin
            step();
            n++;
        end
        check(tag, int'(state), target);
    endtask

    initial begin
        int n, max_st;
        model_reset();
        #2;
        check("por_state", int'(state), 0);
        check("por_bolt", int'(bolt_open), 0);
        check("por_buzzer", int'(buzzer), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();

        // Normal open: 0 -> 1 -> 2 -> 3 -> 0
        unlock = 1'b1;
        run_until("norm_verify", 1, 10);
        run_until("norm_released", 2, 20);
        check("norm_bolt_rel", int'(bolt_open), 1);
        door_closed = 1'b0;
        run_until("norm_door_open", 3, 10);
        repeat (2 * TD) step();
        door_closed = 1'b1;
        run_until("norm_locked", 0, 10);
        check("norm_bolt_end", int'(bolt_open), 0);
        unlock = 1'b0;
        apply_reset(2);

        // Short unlock: one tick of authorization never reaches RELEASED
        unlock = 1'b1;
        max_st = 0;
        for (int i = 0; i < TD; i++) begin
            step();
            if (int'(state) > max_st) max_st = int'(state);
        end
        unlock = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (int'(state) > max_st) max_st = int'(state);
        end
        check("short_max_state", max_st, 1);
        check("short_end", int'(state), 0);

        // Window expiry: RELEASED lasts exactly OW ticks
        unlock = 1'b1;
        run_until("win_released", 2, 30);
        n = 0;
        while (state == 3'd2 && n < 100) begin
            step();
            n++;
        end
        check("win_len", n, OW * TD);
        check("win_bolt", int'(bolt_open), 0);
        unlock = 1'b0;
        repeat (4) step();

        // Ajar: door left open AJAR ticks -> ALARM, held by unlock
        unlock = 1'b1;
        run_until("ajar_released", 2, 40);
        door_closed = 1'b0;
        run_until("ajar_open", 3, 10);
        run_until("ajar_alarm", 4, 40);
        check("ajar_buzzer", int'(buzzer), 1);
        door_closed = 1'b1;
        repeat (10) step();
        check("ajar_hold", int'(state), 4);
        unlock = 1'b0;
        run_until("ajar_clear", 0, 10);

        // Forced entry from LOCKED: sampled edge plus two cycles
        door_closed = 1'b0;
        n = 0;
        while (state != 3'd4 && n < 10) begin
            step();
            n++;
        end
        check("forced_latency", n, 3);
        check("forced_buzzer", int'(buzzer), 1);
        door_closed = 1'b1;
        apply_reset(1);

        // Simultaneous door open and unlock drop in RELEASED
        unlock = 1'b1;
        run_until("sim_released", 2, 40);
        unlock = 1'b0;
        door_closed = 1'b0;
        run_until("sim_door_open", 3, 5);
        run_until("sim_alarm", 4, 40);
        check("sim_alarm_buzzer", int'(buzzer), 1);
        apply_reset(1);
        door_closed = 1'b1;
        repeat (4) step();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(11, 0) == 0) unlock = ~unlock;
            if ($urandom_range(15, 0) == 0) door_closed = ~door_closed;
            if ($urandom_range(999, 0) == 0) apply_reset($urandom_range(3, 1));
            else step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
